// File: rtl/seq_det_ctrl.sv
// Serial pattern detector: programmable pattern/length, optional overlapping
// matches, and a match-count target that ends a run.
module seq_det_ctrl #(
    parameter int MAXLEN = 8,
    parameter int CNTW   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [3:0]        cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNTW-1:0]   cfg_target,
    input  logic              start,
    input  logic              stop,
    input  logic              x,
    input  logic              x_vld,
    output logic              match,
    output logic [CNTW-1:0]   match_cnt,
    output logic              busy,
    output logic              done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              r_state, w_state_nxt;
    logic [MAXLEN-1:0]   r_pattern, w_pattern_nxt;
    logic [3:0]          r_len, w_len_nxt;
    logic                r_overlap, w_overlap_nxt;
    logic [CNTW-1:0]     r_target, w_target_nxt;
    logic [MAXLEN-1:0]   r_hist, w_hist_nxt;
    logic [3:0]          r_fill, w_fill_nxt;
    logic [CNTW-1:0]     r_cnt, w_cnt_nxt;
    logic                r_match, w_match_nxt;
    logic                r_done, w_done_nxt;

    logic [MAXLEN-1:0]   w_mask;
    logic [MAXLEN-1:0]   w_hist_upd;
    logic [3:0]          w_fill_upd;
    logic [CNTW-1:0]     w_cnt_inc;
    logic                w_cfg_ok;
    logic                w_hit;

    // Only the low r_len bits of history and pattern take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAXLEN; i++)
            w_mask[i] = (i < int'(r_len));
    end

    assign w_cfg_ok   = (cfg_len != 4'd0) && (int'(cfg_len) <= MAXLEN);
    assign w_hist_upd = (r_hist << 1) | MAXLEN'(x);
    assign w_fill_upd = (r_fill < r_len) ? r_fill + 4'd1 : r_fill;
    assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNTW'(1);
    assign w_hit      = (w_fill_upd >= r_len) &&
                        ((w_hist_upd & w_mask) == (r_pattern & w_mask));

    always_comb begin
        w_state_nxt   = r_state;
        w_pattern_nxt = r_pattern;
        w_len_nxt     = r_len;
        w_overlap_nxt = r_overlap;
        w_target_nxt  = r_target;
        w_hist_nxt    = r_hist;
        w_fill_nxt    = r_fill;
        w_cnt_nxt     = r_cnt;
        w_match_nxt   = 1'b0;
        w_done_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_we && w_cfg_ok) begin
                    w_pattern_nxt = cfg_pattern;
                    w_len_nxt     = cfg_len;
                    w_overlap_nxt = cfg_overlap;
                    w_target_nxt  = cfg_target;
                end
                if (start && !stop) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                    w_hist_nxt  = '0;
                    w_fill_nxt  = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                end else if (x_vld) begin
                    w_hist_nxt = w_hist_upd;
                    w_fill_nxt = w_fill_upd;
                    if (w_hit) begin
                        w_match_nxt = 1'b1;
                        w_cnt_nxt   = w_cnt_inc;
                        // Without overlap the next match must be built from fresh bits.
                        if (!r_overlap)
                            w_fill_nxt = '0;
                        if ((r_target != '0) && (w_cnt_inc == r_target)) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pattern <= '0;
            r_len     <= 4'd1;
            r_overlap <= 1'b0;
            r_target  <= '0;
            r_hist    <= '0;
            r_fill    <= '0;
            r_cnt     <= '0;
            r_match   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pattern <= w_pattern_nxt;
            r_len     <= w_len_nxt;
            r_overlap <= w_overlap_nxt;
            r_target  <= w_target_nxt;
            r_hist    <= w_hist_nxt;
            r_fill    <= w_fill_nxt;
            r_cnt     <= w_cnt_nxt;
            r_match   <= w_match_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign match     = r_match;
    assign done      = r_done;
    assign match_cnt = r_cnt;
    assign busy      = (r_state == RUN);

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: per-cycle stimulus records carry the expected
// registered outputs; a scoreboard queue pairs each record with the following edge.
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = 4'd1;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_target = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       x = 1'b0;
    logic       x_vld = 1'b0;
    logic       match;
    logic [7:0] match_cnt;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    seq_det_ctrl #(.MAXLEN(8), .CNTW(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
        .start(start), .stop(stop), .x(x), .x_vld(x_vld),
        .match(match), .match_cnt(match_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       rst, we;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ov;
        logic [7:0] tgt;
        logic       st, sp, xb, xv;
        logic       em, ed, eb;
        logic [7:0] ec;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];

    function automatic vec_t v(input string tag, input logic r, input logic we,
                               input logic [7:0] pat, input logic [3:0] len,
                               input logic ov, input logic [7:0] tgt,
                               input logic st, input logic sp, input logic xb,
                               input logic xv, input logic em, input logic ed,
                               input logic eb, input logic [7:0] ec);
        vec_t t;
        t.tag = tag; t.rst = r; t.we = we; t.pat = pat; t.len = len; t.ov = ov;
        t.tgt = tgt; t.st = st; t.sp = sp; t.xb = xb; t.xv = xv;
        t.em = em; t.ed = ed; t.eb = eb; t.ec = ec;
        return t;
    endfunction

    // Plain run cycles: no reset, no config write.
    function automatic vec_t c(input string tag, input logic st, input logic sp,
                               input logic xb, input logic xv, input logic em,
                               input logic ed, input logic eb, input logic [7:0] ec);
        return v(tag, 0, 0, 8'h00, 4'd1, 0, 8'h00, st, sp, xb, xv, em, ed, eb, ec);
    endfunction

    task automatic apply(input vec_t t);
        @(negedge clk);
        rst = t.rst; cfg_we = t.we; cfg_pattern = t.pat; cfg_len = t.len;
        cfg_overlap = t.ov; cfg_target = t.tgt; start = t.st; stop = t.sp;
        x = t.xb; x_vld = t.xv;
        exp_q.push_back(t);
    endtask

    // Scoreboard: one expected record consumed just after each rising edge.
    initial forever begin
        vec_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (match !== e.em || done !== e.ed || busy !== e.eb || match_cnt !== e.ec) begin
                errors++;
                $display("FAIL %s: got m=%0b d=%0b b=%0b cnt=%0d, want m=%0b d=%0b b=%0b cnt=%0d",
                         e.tag, match, done, busy, match_cnt, e.em, e.ed, e.eb, e.ec);
            end
        end
    end

    initial begin
        // Reset held with start asserted, then one quiet cycle after release.
        tbl.push_back(v("rst_a", 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v("rst_b", 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(c("rst_rel", 0, 0, 0, 0, 0, 0, 0, 0));
        // Overlap: 101 in 1,0,1,0,1
        tbl.push_back(v("ov_cfg", 0, 1, 8'b101, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(c("ov_start", 1, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(c("ov_b1", 0, 0, 1, 1, 0, 0, 1, 0));
        tbl.push_back(c("ov_b2", 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(c("ov_b3", 0, 0, 1, 1, 1, 0, 1, 1));
        tbl.push_back(c("ov_b4", 0, 0, 0, 1, 0, 0, 1, 1));
        tbl.push_back(c("ov_b5", 0, 0, 1, 1, 1, 0, 1, 2));
        tbl.push_back(c("ov_stop", 0, 1, 0, 0, 0, 0, 0, 2));
        tbl.push_back(c("idle_x", 0, 0, 1, 1, 0, 0, 0, 2));
        tbl.push_back(c("st_sp", 1, 1, 0, 0, 0, 0, 0, 2));
        // Non-overlap with x_vld gaps
        tbl.push_back(v("no_cfg", 0, 1, 8'b101, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(c("no_start", 1, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(c("no_b1", 0, 0, 1, 1, 0, 0, 1, 0));
        tbl.push_back(c("no_gap1", 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(c("no_b2", 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(c("no_gap2", 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(c("no_b3", 0, 0, 1, 1, 1, 0, 1, 1));
        tbl.push_back(c("no_gap3", 0, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(c("no_b4", 0, 0, 0, 1, 0, 0, 1, 1));
        tbl.push_back(c("no_b5", 0, 0, 1, 1, 0, 0, 1, 1));
        tbl.push_back(c("no_stop", 0, 1, 0, 0, 0, 0, 0, 1));
        // Target of 3 with 11 on a run of ones
        tbl.push_back(v("tg_cfg", 0, 1, 8'b11, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(c("tg_start", 1, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(c("tg_b1", 0, 0, 1, 1, 0, 0, 1, 0));
        tbl.push_back(c("tg_b2", 0, 0, 1, 1, 1, 0, 1, 1));
        tbl.push_back(c("tg_b3", 0, 0, 1, 1, 1, 0, 1, 2));
        tbl.push_back(c("tg_b4", 0, 0, 1, 1, 1, 1, 0, 3));
        tbl.push_back(c("tg_b5", 0, 0, 1, 1, 0, 0, 0, 3));
        tbl.push_back(c("tg_hold", 0, 0, 0, 0, 0, 0, 0, 3));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i]);

        // Abort and config-lock: write in RUN ignored, stop drops the sample.
        apply(v("ab_cfg", 0, 1, 8'b101, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
        apply(c("ab_start", 1, 0, 0, 0, 0, 0, 1, 0));
        apply(v("ab_runcfg", 0, 1, 8'b11111, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        apply(c("ab_b1", 0, 0, 1, 1, 0, 0, 1, 0));
        apply(c("ab_b2", 0, 0, 0, 1, 0, 0, 1, 0));
        apply(c("ab_b3", 0, 0, 1, 1, 1, 0, 1, 1));
        apply(c("ab_b4", 0, 0, 1, 1, 0, 0, 1, 1));
        apply(c("ab_b5", 0, 0, 0, 1, 0, 0, 1, 1));
        apply(c("ab_stop", 0, 1, 1, 1, 0, 0, 0, 1));
        apply(c("ab_keep", 0, 0, 0, 0, 0, 0, 0, 1));
        apply(v("ab_len0", 0, 1, 8'b111, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        apply(c("ab_start2", 1, 0, 0, 0, 0, 0, 1, 0));
        apply(c("ab_c1", 0, 0, 1, 1, 0, 0, 1, 0));
        apply(c("ab_c2", 0, 0, 1, 1, 0, 0, 1, 0));
        apply(c("ab_c3", 0, 0, 1, 1, 0, 0, 1, 0));
        apply(c("ab_c4", 0, 0, 0, 1, 0, 0, 1, 0));
        apply(c("ab_c5", 0, 0, 1, 1, 1, 0, 1, 1));
        apply(c("ab_stop2", 0, 1, 0, 0, 0, 0, 0, 1));

        // Reset in the middle of a run restores default config (pattern 0, len 1).
        apply(v("mr_cfg", 0, 1, 8'b101, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        apply(c("mr_start", 1, 0, 0, 0, 0, 0, 1, 0));
        apply(c("mr_b1", 0, 0, 1, 1, 0, 0, 1, 0));
        apply(c("mr_b2", 0, 0, 0, 1, 0, 0, 1, 0));
        apply(v("mr_rst", 1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        apply(c("mr_b3", 0, 0, 1, 1, 0, 0, 0, 0));
        apply(c("mr_start2", 1, 0, 0, 0, 0, 0, 1, 0));
        apply(c("mr_d1", 0, 0, 1, 1, 0, 0, 1, 0));
        apply(c("mr_d0", 0, 0, 0, 1, 1, 0, 1, 1));
        apply(c("mr_idle", 0, 1, 0, 0, 0, 0, 0, 1));

        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d records unchecked, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 SHALL have parameter MAXLEN, default 8: maximum pattern length in bits.
REQ-002 SHALL have parameter CNTW, default 8: match counter and target width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 SHALL have port cfg_we  input  1  config write strobe.
REQ-006 SHALL have port cfg_pattern  input  MAXLEN  pattern; bit [len-1] is the first serial bit, bit [0] the last.
REQ-007 SHALL have port cfg_len  input  4  pattern length, legal range 1..MAXLEN.
REQ-008 SHALL have port cfg_overlap  input  1  1 = overlapping matches allowed.
REQ-009 SHALL have port cfg_target  input  CNTW  match count that ends a run; 0 = unlimited.
REQ-010 SHALL have port start  input  1  begin a detection run.
REQ-011 SHALL have port stop  input  1  abort the current run.
REQ-012 SHALL have port x  input  1  serial data bit.
REQ-013 SHALL have port x_vld  input  1  x is valid this cycle.
REQ-014 SHALL have port match  output  1  registered one-cycle pulse per detected pattern.
REQ-015 SHALL have port match_cnt  output  CNTW  matches in the current or last run.
REQ-016 SHALL have port busy  output  1  high while in RUN.
REQ-017 SHALL have port done  output  1  one-cycle pulse when the target count is reached.

Function
REQ-018 SHALL have FSM states IDLE and RUN; busy = (state == RUN).
REQ-019 IDLE SHALL go to RUN on start=1 with stop=0; start with stop in the same cycle SHALL be ignored.
REQ-020 On entering RUN: match_cnt, history shift register and fill count SHALL be cleared to 0.
REQ-021 cfg_we SHALL latch all cfg_* fields only in IDLE; in RUN it is ignored.
REQ-022 A cfg_we with cfg_len=0 or cfg_len>MAXLEN SHALL be rejected entirely; the previous config is kept.
REQ-023 In RUN, each x_vld=1 cycle SHALL shift x into history at the LSB and increment fill, saturating at cfg_len.
REQ-024 A match SHALL occur when updated fill >= cfg_len and updated history[len-1:0] == pattern[len-1:0].
REQ-025 On a match, match SHALL pulse 1 in the cycle after the completing sample, and match_cnt SHALL increment in that same cycle, saturating at all-ones.
REQ-026 After a match: overlap=1 leaves fill unchanged; overlap=0 clears fill to 0, so no bit is reused.
REQ-027 If cfg_target != 0 and the incremented match_cnt equals cfg_target: done SHALL pulse together with match, and the FSM SHALL return to IDLE.
REQ-028 stop=1 in RUN SHALL return the FSM to IDLE next cycle and drop that cycle's x sample; match_cnt is retained, done and match stay 0.
REQ-029 x_vld=0 cycles SHALL leave history, fill and outputs unchanged, apart from clearing the match/done pulses.
REQ-030 In IDLE, x and x_vld SHALL be ignored, and match_cnt SHALL hold its last-run value until the next start.

Reset
REQ-031 rst=1 SHALL force state=IDLE and match=0, done=0, busy=0, match_cnt=0, history=0, fill=0.
REQ-032 rst=1 SHALL set the config registers to pattern=0, len=1, overlap=0, target=0.
REQ-033 rst SHALL override all other inputs in the same cycle, including mid-run.

Verification
REQ-034 Reset: assert rst 2 cycles with start=1 -> busy=0, match=0, done=0, match_cnt=0 throughout, and for 1 cycle after release.
REQ-035 Overlap: pattern=3'b101, len=3, overlap=1, target=0; start; x=1,0,1,0,1 -> match after the 3rd and 5th bits, match_cnt=2, busy=1.
REQ-036 Non-overlap: same config with overlap=0, same stream -> a single match after the 3rd bit, match_cnt=1; gaps with x_vld=0 inserted change nothing.
REQ-037 Target: pattern=2'b11, len=2, overlap=1, target=3; stream 1,1,1,1,1 -> match on bits 2,3,4; done with the 3rd match; busy=0 next cycle; bit 5 ignored.
REQ-038 Abort/config: in RUN, cfg_we with len=5 is ignored; stop mid-pattern -> IDLE, match_cnt kept; cfg_we with len=0 in IDLE is rejected.
REQ-039 Mid-run reset: rst one cycle after the 2nd bit of 3'b101 -> all outputs 0, config back to defaults, no match on later bits.
